max_scan_ctrl: RTL and testbench

//   Sequences a stream of signed DATA_W-bit samples through one shared two-input max comparator.

---
 rtl/max_scan_pkg.sv | 19 +
 rtl/signed_max_cmp.sv | 29 ++
 rtl/max_scan_ctrl.sv | 115 +++++++++++
 tb/tb_max_scan_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/max_scan_pkg.sv
// rtl/max_scan_pkg.sv - shared types and constants for the max scan controller
// Purpose: controller state encoding, default sample width, signed sample limits.
// Ports: none (package).
package max_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int DATA_W_DFLT = 3;

  // Extremes of a DATA_W_DFLT-bit two's complement sample.
  localparam logic signed [DATA_W_DFLT-1:0] SMIN = 3'b100;
  localparam logic signed [DATA_W_DFLT-1:0] SMAX = 3'b011;

endpackage

// File: rtl/signed_max_cmp.sv
// rtl/signed_max_cmp.sv - combinational two-input signed max comparator
// Purpose: selects the larger of two two's complement values.
// Ports:
//   a, b    in   DATA_W  operands, signed
//   max     out  DATA_W  larger operand (b when equal)
//   a_gt_b  out  1       a strictly greater than b
module signed_max_cmp
  import max_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] max,
  output logic              a_gt_b
);

  always_comb begin
    if (a[DATA_W-1] != b[DATA_W-1]) begin
      // Differing signs: whichever operand is non-negative is larger.
      a_gt_b = ~a[DATA_W-1];
    end else begin
      // Same sign: the remaining bits order the values directly.
      a_gt_b = (a[DATA_W-2:0] > b[DATA_W-2:0]);
    end
    max = a_gt_b ? a : b;
  end

endmodule

// File: rtl/max_scan_ctrl.sv
// rtl/max_scan_ctrl.sv - frame maximum / index scanner around one shared comparator
// Purpose: accepts FRAME_LEN signed samples per frame and reports the maximum
//          and the index of its first occurrence.
// Ports:
//   clk, rst            clock (rising), asynchronous active-high reset
//   start               begin a frame (IDLE only)
//   in_valid/in_ready   sample handshake, in_data signed sample
//   res_valid/res_ack   result handshake, res_max / res_idx result
//   busy                frame in progress or result pending
module max_scan_ctrl
  import max_scan_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DFLT,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [DATA_W-1:0] res_max,
  output logic [IDX_W-1:0]  res_idx,
  output logic              busy
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] acc;
  logic [IDX_W-1:0]  acc_idx;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] cmp_max;
  logic              cmp_gt;
  logic              hs;
  logic              last;

  assign hs   = in_valid & in_ready;
  assign last = (cnt == IDX_W'(FRAME_LEN - 1));

  signed_max_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .a      (in_data),
    .b      (acc),
    .max    (cmp_max),
    .a_gt_b (cmp_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs are pure decodes of the registered state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        in_ready = 1'b1;
        if (in_valid && last) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        res_valid = 1'b1;
        if (res_ack) state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_idx <= '0;
      cnt     <= '0;
      res_max <= '0;
      res_idx <= '0;
    end else if (hs) begin
      if (state == ST_LOAD) begin
        acc     <= in_data;
        acc_idx <= '0;
        cnt     <= IDX_W'(1);
      end else if (last) begin
        // Final sample bypasses acc and lands straight in the result registers.
        res_max <= cmp_max;
        res_idx <= cmp_gt ? cnt : acc_idx;
        cnt     <= '0;
      end else begin
        acc <= cmp_max;
        if (cmp_gt) acc_idx <= cnt;
        cnt <= cnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb/tb_max_scan_ctrl.sv - scoreboard testbench for max_scan_ctrl
module tb_max_scan_ctrl;
  import max_scan_pkg::*;

  localparam int DW = 3;
  localparam int FL = 8;
  localparam int IW = 3;

  typedef logic signed [DW-1:0] frame_t [FL];

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          res_valid;
  logic          res_ack;
  logic [DW-1:0] res_max;
  logic [IW-1:0] res_idx;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [DW+IW-1:0] exp_q [$];

  always #5 clk = ~clk;

  max_scan_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ack   (res_ack),
    .res_max   (res_max),
    .res_idx   (res_idx),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: largest value, earliest position among equals.
  task automatic ref_max(input frame_t f, output logic signed [DW-1:0] m, output int idx);
    int best;
    best = int'(f[0]);
    idx  = 0;
    for (int i = 1; i < FL; i++) begin
      if (int'(f[i]) > best) begin
        best = int'(f[i]);
        idx  = i;
      end
    end
    m = DW'(best);
  endtask

  // Monitor: consumes one expected entry per result presentation.
  logic             seen = 1'b0;
  logic [DW+IW-1:0] held;
  always @(negedge clk) begin
    logic [DW+IW-1:0] e;
    if (rst) begin
      seen = 1'b0;
    end else if (res_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held = {res_max, res_idx};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got max=%0d idx=%0d with empty scoreboard", $signed(res_max), res_idx);
        end else begin
          e = exp_q.pop_front();
          check("res_max", int'($signed(res_max)), int'($signed(e[DW+IW-1:IW])));
          check("res_idx", int'(res_idx), int'(e[IW-1:0]));
        end
      end else begin
        check("hold_stable", int'({res_max, res_idx}), int'(held));
      end
      check("hold_in_ready", int'(in_ready), 0);
    end else begin
      seen = 1'b0;
    end
  end

  // Called #1 after a rising edge with the DUT in IDLE.
  // mode 0: back-to-back, 1: bubble before each sample, 2: random bubbles and stray acks.
  task automatic send_frame(input frame_t f, input int mode, input int hold, input bit start_in_hold);
    logic signed [DW-1:0] m;
    int idx;
    int g;
    ref_max(f, m, idx);
    exp_q.push_back({m, IW'(idx)});
    check("idle_in_ready", int'(in_ready), 0);
    check("idle_busy", int'(busy), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int i = 0; i < FL; i++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        res_ack  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = f[i];
      g = 0;
      while (!in_ready && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 required 1 at sample %0d", i);
      end
      check("early_valid", int'(res_valid), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    res_ack  = 1'b0;
    check("res_valid_latency", int'(res_valid), 1);
    for (int h = 0; h < hold; h++) begin
      if (start_in_hold && h == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_valid", int'(res_valid), 1);
      check("hold_busy", int'(busy), 1);
    end
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
    check("ack_valid", int'(res_valid), 0);
    check("ack_busy", int'(busy), 0);
    check("ack_in_ready", int'(in_ready), 0);
    if (start_in_hold) begin
      @(posedge clk); #1;
      check("start_not_queued", int'(busy), 0);
    end
  endtask

  initial begin
    frame_t f1, f2, f3, f6, fr;
    f1 = '{3'sd1, -3'sd2, 3'sd3, 3'sd0, 3'b100, 3'sd2, 3'sd3, -3'sd1};
    for (int i = 0; i < FL; i++) f2[i] = SMIN;
    f3 = '{-3'sd1, -3'sd1, -3'sd1, -3'sd1, -3'sd1, -3'sd1, -3'sd1, 3'sd0};

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    res_ack  = 1'b0;
    #2;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_res_max", int'(res_max), 0);
    check("rst_res_idx", int'(res_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send_frame(f1, 0, 0, 1'b0);
    send_frame(f2, 0, 1, 1'b0);
    send_frame(f3, 0, 0, 1'b0);
    send_frame(f1, 1, 2, 1'b0);
    send_frame(f1, 0, 5, 1'b1);

    // Abort after four samples; reset must clear outputs without a clock edge.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = f3[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_res_valid", int'(res_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_res_max", int'(res_max), 0);
    check("abort_res_idx", int'(res_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_no_valid", int'(res_valid), 0);
    @(posedge clk); #1;

    f6[0] = SMAX;
    for (int i = 1; i < FL; i++) f6[i] = DW'($urandom);
    send_frame(f6, 0, 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < FL; i++) fr[i] = DW'($urandom);
      send_frame(fr, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
